// File: rtl/c17_seq_trojan_if.sv
// Lane-vector bus of the c17 trojan block: per-lane c17 inputs/outputs plus
// trigger observation signals.
interface c17_seq_trojan_if #(
    parameter int LANES = 4
);
    logic [LANES-1:0] N1, N2, N3, N6, N7;
    logic [LANES-1:0] N22, N23;
    logic             trojan_active;
    logic [7:0]       trig_cnt;

    modport master (
        output N1, N2, N3, N6, N7,
        input  N22, N23, trojan_active, trig_cnt
    );

    modport slave (
        input  N1, N2, N3, N6, N7,
        output N22, N23, trojan_active, trig_cnt
    );
endinterface

// File: rtl/c17_seq_trojan.sv
// LANES registered c17 netlists with a sequential trigger watching lane 0;
// once armed, a timed payload corrupts every lane's outputs.
module c17_seq_trojan #(
    parameter int         LANES          = 4,
    parameter logic [4:0] TRIG_PATTERN   = 5'b11111,
    parameter int         TRIG_COUNT     = 8,
    parameter int         PAYLOAD_CYCLES = 4,
    parameter bit         PAYLOAD_MODE   = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    c17_seq_trojan_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        PAYLOAD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       trig_cnt_q, trig_cnt_d;
    logic [7:0]       timer_q, timer_d;
    logic             active_q, active_d;
    logic [LANES-1:0] n22_q, n22_d, n23_q, n23_d;
    logic [LANES-1:0] gold22, gold23;
    logic             match;
    logic [8:0]       cnt_next;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic n10, n11, n16, n19;
        assign n10       = ~(bus.N1[i] & bus.N3[i]);
        assign n11       = ~(bus.N3[i] & bus.N6[i]);
        assign n16       = ~(bus.N2[i] & n11);
        assign n19       = ~(n11 & bus.N7[i]);
        assign gold22[i] = ~(n10 & n16);
        assign gold23[i] = ~(n16 & n19);
    end

    assign match = ({bus.N1[0], bus.N2[0], bus.N3[0], bus.N6[0], bus.N7[0]} == TRIG_PATTERN);

    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        timer_d    = timer_q;
        // count this cycle would reach if lane 0 matches; IDLE restarts at 1
        cnt_next   = (state_q == COUNT) ? ({1'b0, trig_cnt_q} + 9'd1) : 9'd1;
        case (state_q)
            IDLE, COUNT: begin
                if (!match) begin
                    state_d    = IDLE;
                    trig_cnt_d = '0;
                end else if (cnt_next >= 9'(TRIG_COUNT)) begin
                    state_d    = PAYLOAD;
                    trig_cnt_d = '0;
                    timer_d    = 8'(PAYLOAD_CYCLES - 1);
                end else begin
                    state_d    = COUNT;
                    trig_cnt_d = (cnt_next > 9'd255) ? 8'hFF : cnt_next[7:0];
                end
            end
            PAYLOAD: begin
                trig_cnt_d = '0;
                if (timer_q == 8'd0) state_d = IDLE;
                else                 timer_d = timer_q - 8'd1;
            end
            default: begin
                state_d    = IDLE;
                trig_cnt_d = '0;
                timer_d    = '0;
            end
        endcase

        // outputs registered while in PAYLOAD carry the corruption
        active_d = (state_q == PAYLOAD);
        n22_d    = gold22;
        n23_d    = gold23;
        if (active_d) begin
            if (PAYLOAD_MODE) begin
                n22_d = ~gold22;
                n23_d = ~gold23;
            end else begin
                n22_d = '0;
                n23_d = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            trig_cnt_q <= '0;
            timer_q    <= '0;
            active_q   <= 1'b0;
            n22_q      <= '0;
            n23_q      <= '0;
        end else begin
            state_q    <= state_d;
            trig_cnt_q <= trig_cnt_d;
            timer_q    <= timer_d;
            active_q   <= active_d;
            n22_q      <= n22_d;
            n23_q      <= n23_d;
        end
    end

    assign bus.N22           = n22_q;
    assign bus.N23           = n23_q;
    assign bus.trojan_active = active_q;
    assign bus.trig_cnt      = trig_cnt_q;
endmodule

// File: tb/tb_c17_seq_trojan.sv
// Bench for c17_seq_trojan: three configurations share one stimulus stream and
// are checked every cycle against a run-length / payload-budget model.
module tb_c17_seq_trojan;
    logic clk = 1'b0;
    logic rst_n;
    logic chk_en;
    logic [3:0] n1, n2, n3, n6, n7;

    always #5 clk = ~clk;

    // u0: defaults, u1: inverting payload, u2: single-match / single-cycle payload
    localparam int TC [3] = '{8, 8, 1};
    localparam int PC [3] = '{4, 4, 1};
    localparam bit PM [3] = '{1'b0, 1'b1, 1'b0};

    c17_seq_trojan_if #(.LANES(4)) if0 ();
    c17_seq_trojan_if #(.LANES(4)) if1 ();
    c17_seq_trojan_if #(.LANES(4)) if2 ();

    assign if0.N1 = n1; assign if0.N2 = n2; assign if0.N3 = n3; assign if0.N6 = n6; assign if0.N7 = n7;
    assign if1.N1 = n1; assign if1.N2 = n2; assign if1.N3 = n3; assign if1.N6 = n6; assign if1.N7 = n7;
    assign if2.N1 = n1; assign if2.N2 = n2; assign if2.N3 = n3; assign if2.N6 = n6; assign if2.N7 = n7;

    c17_seq_trojan #(.LANES(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    c17_seq_trojan #(.LANES(4), .PAYLOAD_MODE(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    c17_seq_trojan #(.LANES(4), .TRIG_COUNT(1), .PAYLOAD_CYCLES(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [2:0][3:0] d22, d23;
    logic [2:0][7:0] dcnt;
    logic [2:0]      dact;
    assign d22[0] = if0.N22; assign d23[0] = if0.N23; assign dcnt[0] = if0.trig_cnt; assign dact[0] = if0.trojan_active;
    assign d22[1] = if1.N22; assign d23[1] = if1.N23; assign dcnt[1] = if1.trig_cnt; assign dact[1] = if1.trojan_active;
    assign d22[2] = if2.N22; assign d23[2] = if2.N23; assign dcnt[2] = if2.trig_cnt; assign dact[2] = if2.trojan_active;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: run = consecutive lane-0 matches, pay = payload output cycles still owed.
    int              run [3];
    int              pay [3];
    logic [2:0][3:0] e22, e23;
    logic [2:0][7:0] ecnt;
    logic [2:0]      eact;

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] g22, g23, nand36;
        bit         m;
        int         r, p;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                run[k]  <= 0;
                pay[k]  <= 0;
                e22[k]  <= 4'h0;
                e23[k]  <= 4'h0;
                ecnt[k] <= 8'h00;
                eact[k] <= 1'b0;
            end
        end else begin
            nand36 = ~(n3 & n6);
            g22    = (n1 & n3) | (n2 & nand36);
            g23    = nand36 & (n2 | n7);
            m      = ({n1[0], n2[0], n3[0], n6[0], n7[0]} == 5'b11111);
            for (int k = 0; k < 3; k++) begin
                r = run[k];
                p = pay[k];
                if (p > 0) begin
                    eact[k] <= 1'b1;
                    e22[k]  <= PM[k] ? ~g22 : 4'h0;
                    e23[k]  <= PM[k] ? ~g23 : 4'hF;
                    p = p - 1;
                    r = 0;
                end else begin
                    eact[k] <= 1'b0;
                    e22[k]  <= g22;
                    e23[k]  <= g23;
                    if (m) begin
                        r = (r < 255) ? r + 1 : 255;
                        if (r >= TC[k]) begin
                            p = PC[k];
                            r = 0;
                        end
                    end else begin
                        r = 0;
                    end
                end
                run[k]  <= r;
                pay[k]  <= p;
                ecnt[k] <= 8'(r);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("cyc_n22", k, {4'h0, d22[k]}, {4'h0, e22[k]});
                chk("cyc_n23", k, {4'h0, d23[k]}, {4'h0, e23[k]});
                chk("cyc_cnt", k, dcnt[k], ecnt[k]);
                chk("cyc_act", k, {7'h0, dact[k]}, {7'h0, eact[k]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lane 0 gets l0; other lanes get l0 too (repl) or random values
    task automatic drive(input logic [4:0] l0, input bit repl);
        logic [4:0] ln;
        for (int i = 0; i < 4; i++) begin
            ln = (i == 0 || repl) ? l0 : 5'($urandom);
            n1[i] = ln[4]; n2[i] = ln[3]; n3[i] = ln[2]; n6[i] = ln[1]; n7[i] = ln[0];
        end
    endtask

    function automatic logic [4:0] nonpat();
        logic [4:0] v;
        v = 5'($urandom);
        if (v == 5'b11111) v = 5'b11110;
        return v;
    endfunction

    initial begin
        rst_n  = 1'b0;
        chk_en = 1'b0;
        drive(5'b00000, 1'b1);
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_n22", k, {4'h0, d22[k]}, 8'h00);
            chk("rst_n23", k, {4'h0, d23[k]}, 8'h00);
            chk("rst_cnt", k, dcnt[k], 8'h00);
            chk("rst_act", k, {7'h0, dact[k]}, 8'h00);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // random traffic that never matches the trigger pattern
        for (int c = 0; c < 100; c++) begin
            drive(nonpat(), 1'b0);
            tick();
            chk("idle_act", 0, {7'h0, dact[0]}, 8'h00);
        end

        // 8 matching cycles, then all-zero inputs during the payload window
        for (int c = 1; c <= 8; c++) begin
            drive(5'b11111, 1'b1);
            tick();
            chk("arm_cnt", 0, dcnt[0], (c < 8) ? 8'(c) : 8'h00);
        end
        chk("arm_act", 0, {7'h0, dact[0]}, 8'h00);
        for (int c = 0; c < 4; c++) begin
            drive(5'b00000, 1'b1);
            tick();
            chk("pay_act",  0, {7'h0, dact[0]}, 8'h01);
            chk("pay0_n22", 0, {4'h0, d22[0]}, 8'h00);
            chk("pay0_n23", 0, {4'h0, d23[0]}, 8'h0F);
            chk("pay1_n22", 1, {4'h0, d22[1]}, 8'h0F);
            chk("pay1_n23", 1, {4'h0, d23[1]}, 8'h0F);
        end
        drive(5'b00000, 1'b1);
        tick();
        chk("post_act", 0, {7'h0, dact[0]}, 8'h00);
        chk("post_n22", 1, {4'h0, d22[1]}, 8'h00);
        chk("post_n23", 1, {4'h0, d23[1]}, 8'h00);

        // 7 matches, a break, 7 matches: never arms
        for (int c = 0; c < 7; c++) begin drive(5'b11111, 1'b0); tick(); end
        chk("run7_cnt", 0, dcnt[0], 8'd7);
        drive(nonpat(), 1'b0);
        tick();
        chk("brk_cnt", 0, dcnt[0], 8'h00);
        for (int c = 0; c < 7; c++) begin
            drive(5'b11111, 1'b0);
            tick();
            chk("brk_act", 0, {7'h0, dact[0]}, 8'h00);
        end
        chk("run7b_cnt", 0, dcnt[0], 8'd7);
        drive(nonpat(), 1'b0);
        tick();
        chk("brk2_cnt", 0, dcnt[0], 8'h00);

        // arm, then reset during the second payload cycle
        for (int c = 0; c < 8; c++) begin drive(5'b11111, 1'b0); tick(); end
        drive(nonpat(), 1'b0);
        tick();
        chk("p1_act", 0, {7'h0, dact[0]}, 8'h01);
        drive(nonpat(), 1'b0);
        tick();
        chk("p2_act", 0, {7'h0, dact[0]}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_n22", 0, {4'h0, d22[0]}, 8'h00);
        chk("arst_n23", 0, {4'h0, d23[0]}, 8'h00);
        chk("arst_act", 0, {7'h0, dact[0]}, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(nonpat(), 1'b0);
            tick();
            chk("rel_act", 0, {7'h0, dact[0]}, 8'h00);
        end

        // single-match trigger on u2
        drive(5'b11111, 1'b0);
        tick();
        chk("one_enter", 2, {7'h0, dact[2]}, 8'h00);
        drive(nonpat(), 1'b0);
        tick();
        chk("one_act", 2, {7'h0, dact[2]}, 8'h01);
        drive(nonpat(), 1'b0);
        tick();
        chk("one_done", 2, {7'h0, dact[2]}, 8'h00);

        // mixed random traffic with frequent trigger matches
        for (int c = 0; c < 200; c++) begin
            drive(($urandom_range(0, 9) < 7) ? 5'b11111 : 5'($urandom), 1'b0);
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
